// File: rtl/instr_loader.sv
// Run-time instruction memory loader: assembles big-endian words from a byte
// stream and writes them to consecutive word addresses while holding the CPU.
module instr_loader #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] word_count_i,
  input  logic             abort_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_waddr_o,
  output logic [31:0]      mem_wdata_o,
  output logic             busy_o,
  output logic             cpu_hold_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_e;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] widx_q, widx_d;
  logic [1:0]       bidx_q, bidx_d;
  logic [23:0]      asm_q, asm_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_d;
  logic             rdy_q, we_q, busy_q, done_q, err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (word_count_i != '0 && word_count_i <= DEPTH_C) begin
            cnt_d   = word_count_i;
            widx_d  = '0;
            bidx_d  = '0;
            state_d = S_RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RECV: begin
        // abort wins over a simultaneous 4th byte, dropping the partial word
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (byte_valid_i) begin
          asm_d  = {asm_q[15:0], byte_data_i};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            waddr_d = {{(30-CNT_W){1'b0}}, widx_q, 2'b00};
            wdata_d = {asm_q, byte_data_i};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          widx_d  = widx_q + 1'b1;
          bidx_d  = '0;
          state_d = (widx_q == cnt_q - 1'b1) ? S_DONE : S_RECV;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered decodes of the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdy_q   <= (state_d == S_RECV);
      we_q    <= (state_d == S_WRITE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      err_q   <= err_d;
    end
  end

  assign byte_ready_o = rdy_q;
  assign mem_we_o     = we_q;
  assign mem_waddr_o  = waddr_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = busy_q;
  assign cpu_hold_o   = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed and random loads checked against a
// byte-list reference (word w = bytes 4w..4w+3, big-endian, at address 4w).
module tb_instr_loader;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [5:0]  word_count_i = '0;
  logic        abort_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = '0;
  logic        byte_ready_o, mem_we_o, busy_o, cpu_hold_o, done_o, err_o;
  logic [31:0] mem_waddr_o, mem_wdata_o;

  instr_loader #(.DEPTH(32), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .word_count_i(word_count_i),
    .abort_i(abort_i), .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(byte_ready_o), .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o), .busy_o(busy_o), .cpu_hold_o(cpu_hold_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, we_total = 0, last_done = 0;
  logic mon_en = 1'b0, prev_we = 1'b0, prev_done = 1'b0;
  logic [63:0] obs[$];
  int we_cyc[$];
  logic [7:0] bq[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // per-cycle protocol observations
  always @(negedge clk_i) if (mon_en) begin
    chk("hold_eq_busy", 64'(cpu_hold_o), 64'(busy_o));
    if (prev_we) chk("we_one_cycle", 64'(mem_we_o), 64'd0);
    if (prev_done) begin
      chk("busy_after_done", 64'(busy_o), 64'd0);
      chk("done_one_cycle", 64'(done_o), 64'd0);
    end
    if (mem_we_o) begin
      chk("ready_low_in_write", 64'(byte_ready_o), 64'd0);
      obs.push_back({mem_waddr_o, mem_wdata_o});
      we_cyc.push_back(cyc);
      we_total++;
    end
    if (done_o) begin done_cnt++; last_done = cyc; end
    if (err_o) err_cnt++;
    prev_we = mem_we_o;
    prev_done = done_o;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, 64'({byte_ready_o, mem_we_o, busy_o, cpu_hold_o, done_o, err_o}), 64'd0);
    chk({tag, "_addr_data"}, {mem_waddr_o, mem_wdata_o}, 64'd0);
  endtask

  task automatic fill_rand(input int n);
    bq.delete();
    for (int j = 0; j < n; j++) bq.push_back(8'($urandom));
  endtask

  // mode 0: continuous valid, 1: valid pattern 1,0,0,1 plus a start while busy, 2: random
  task automatic run_load(input int cnt, input int mode, input int abort_idx, input int rst_idx);
    int d0 = done_cnt, e0 = err_cnt, s, i = 0, k = 0, nexp, t;
    bit xf, stop = 0, aborted = 0, was_rst = 0;
    logic v;
    logic [31:0] word;
    obs.delete(); we_cyc.delete();
    start_i = 1'b1; word_count_i = 6'(cnt); s = cyc;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    while (i < bq.size() && !stop) begin
      if (i == rst_idx) begin
        byte_valid_i = 1'b0;
        rst_n_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk_zero("reset_mid_load");
        rst_n_i = 1'b1;
        was_rst = 1;
        @(posedge clk_i); #1;
        break;
      end
      case (mode)
        0: v = 1'b1;
        1: v = (k % 4 == 0) || (k % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid_i = v;
      byte_data_i = bq[i];
      abort_i = (i == abort_idx) && v && byte_ready_o;
      if (mode == 1 && k == 3) begin start_i = 1'b1; word_count_i = 6'd5; end
      @(negedge clk_i);
      chk("hold_in_session", 64'(cpu_hold_o), 64'd1);
      xf = byte_valid_i && byte_ready_o;
      @(posedge clk_i); #1;
      if (abort_i) begin stop = 1; aborted = 1; end
      abort_i = 1'b0;
      start_i = 1'b0;
      if (xf) i++;
      k++;
      if (k > 3000) begin chk("feed_timeout", 64'(k), 64'd0); stop = 1; end
    end
    byte_valid_i = 1'b0;
    if (aborted) chk("idle_after_abort", 64'(busy_o), 64'd0);
    t = 0;
    while (busy_o && t < 20) begin @(posedge clk_i); #1; t++; end
    chk("idle_after_load", 64'(busy_o), 64'd0);
    repeat (2) begin @(posedge clk_i); #1; end
    nexp = was_rst ? 0 : (aborted ? abort_idx / 4 : cnt);
    chk("num_writes", 64'(obs.size()), 64'(nexp));
    for (int w = 0; w < nexp && w < obs.size(); w++) begin
      word = {bq[4*w], bq[4*w+1], bq[4*w+2], bq[4*w+3]};
      chk("write_addr_data", obs[w], {32'(4 * w), word});
    end
    chk("done_pulses", 64'(done_cnt - d0), (aborted || was_rst) ? 64'd0 : 64'd1);
    chk("no_err_in_load", 64'(err_cnt - e0), 64'd0);
    if (mode == 0 && !aborted && !was_rst && we_cyc.size() > 0) begin
      chk("first_write_cycle", 64'(we_cyc[0]), 64'(s + 5));
      chk("done_cycle", 64'(last_done), 64'(s + 5 * cnt + 1));
    end
  endtask

  task automatic reject(input int wc);
    int e0 = err_cnt, w0 = we_total;
    start_i = 1'b1; word_count_i = 6'(wc);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("err_pulse", 64'(err_o), 64'd1);
    chk("busy_on_reject", 64'(busy_o), 64'd0);
    repeat (2) begin @(posedge clk_i); #1; end
    chk("err_once", 64'(err_cnt - e0), 64'd1);
    chk("no_write_on_reject", 64'(we_total - w0), 64'd0);
    chk("idle_after_reject", 64'(busy_o), 64'd0);
  endtask

  initial begin
    // reset with random inputs
    for (int c = 0; c < 3; c++) begin
      start_i = 1'($urandom); word_count_i = 6'($urandom); abort_i = 1'($urandom);
      byte_valid_i = 1'($urandom); byte_data_i = 8'($urandom);
      @(negedge clk_i);
      if (c > 0) chk_zero("reset");
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk_zero("reset_end");
    start_i = 1'b0; abort_i = 1'b0; byte_valid_i = 1'b0; word_count_i = '0;
    rst_n_i = 1'b1;
    mon_en = 1'b1;
    @(posedge clk_i); #1;

    bq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(2, 0, -1, -1);
    run_load(2, 1, -1, -1);

    reject(0);
    reject(33);

    fill_rand(8);
    run_load(2, 0, -1, 2);
    bq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_load(1, 0, -1, -1);

    fill_rand(8);
    run_load(2, 0, 7, -1);

    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 8);
      fill_rand(4 * n);
      run_load(n, 2, -1, -1);
    end

    fill_rand(128);
    run_load(32, 0, -1, -1);
    if (obs.size() == 32) chk("last_addr", 64'(obs[31][63:32]), 64'h7C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Loads a program into the CPU's word-organised instruction memory at run time, replacing the simulation-only file preload. It takes a byte stream over a valid/ready handshake, assembles big-endian 32-bit instructions and issues one word write per instruction at consecutive byte addresses 0, 4, 8, and so on. `cpu_hold` keeps the core stalled while a load is in progress. It sits between the host/UART byte source and the write port of the instruction memory.

## Interface
- `DEPTH`, default 32: instruction memory size in words; legal `word_count` is 1..DEPTH.
- `CNT_W`, default 6: width of `word_count`, which must be able to hold the value DEPTH.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request to begin a load session; sampled only in IDLE.
- `word_count` in CNT_W: number of words to load; sampled together with `start`.
- `abort` in 1: cancel the current session; takes effect in any non-IDLE state.
- `byte_valid` in 1: source has a byte on `byte_data`.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: one-cycle write strobe to the instruction memory.
- `mem_waddr` out 32: byte address of the write (word index << 2), matching the memory's `pc>>2` indexing.
- `mem_wdata` out 32: assembled instruction.
- `busy` out 1: a session is active (RECV/WRITE/DONE).
- `cpu_hold` out 1: equal to `busy`; stalls the CPU's program counter.
- `done` out 1: one-cycle pulse when all `word_count` words have been written.
- `err` out 1: one-cycle pulse when `start` is rejected.

## Operation
- All outputs are registered.
- Reset values: `byte_ready`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `busy`=0, `cpu_hold`=0, `done`=0, `err`=0.
- Internal reset state: IDLE, word index 0, byte index 0, assembly register 0.
- A transfer occurs in any cycle with `byte_valid` && `byte_ready`. `byte_data` is consumed only on a transfer.
- Byte order is big-endian. The first byte of each word goes to [31:24], then [23:16], [15:8], and the last byte to [7:0].
- State machine:
  - IDLE: `byte_ready`=0.
    - On `start` with 1 ≤ `word_count` ≤ DEPTH: latch the count, clear the word and byte indices, go to RECV.
    - On `start` with `word_count`=0 or `word_count` > DEPTH: pulse `err`, stay in IDLE, no writes.
  - RECV: `byte_ready`=1.
    - Each transfer stores the byte and increments the byte index.
    - The transfer of the 4th byte moves to WRITE, and `byte_ready` drops in the next cycle.
  - WRITE: for exactly one cycle, `mem_we`=1, `mem_waddr`={word_idx,2'b00}, `mem_wdata` = assembled word, `byte_ready`=0.
    - Then the word index increments and the byte index clears.
    - Go to DONE if this was word `word_count`-1, else back to RECV.
  - DONE: `done`=1 for one cycle, then go to IDLE with `busy` dropping.
- `start` outside IDLE is ignored: no `err`, no effect on the session.
- `abort` in RECV, WRITE or DONE returns to IDLE on the next edge.
  - No further `mem_we`, and no `done` pulse.
  - If asserted during WRITE, that cycle's write still completes, because `mem_we` is already registered.
  - Words already written stay in memory.
- `abort` has priority over a simultaneous 4th-byte transfer: the partial word is discarded.
- `rst_n` low mid-session: all outputs return to reset values at that edge; no partial write is ever issued.
- `mem_waddr` and `mem_wdata` hold their last written values outside WRITE. Only `mem_we` qualifies them.

## Timing
- Accepting a byte costs one cycle when `byte_valid` is held high.
- If the 4th byte of a word transfers in cycle N:
  - `mem_we` is high in cycle N+1.
  - `byte_ready` is low in N+1 and high again in N+2 if more words remain.
- Maximum throughput: 5 cycles per word.
- `done` is high in the cycle after the last WRITE cycle. `busy` and `cpu_hold` are low in the cycle after `done`.
- `start` accepted in cycle S: `busy`=1 and `byte_ready`=1 from S+1.
- `err` is high in cycle S+1 for a rejected `start`.
- Full DEPTH=32 load with no gaps: 32×5 + 1 (DONE) cycles after entering RECV.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random inputs -> every output 0, `mem_we` never asserted.
- Two-word load: `start`, `word_count`=2, bytes 12 34 56 78 DE AD BE EF with `byte_valid` continuous -> writes (0x00000000, 0x12345678) and (0x00000004, 0xDEADBEEF), each `mem_we` one cycle wide, `done` one cycle after the second write, `busy` low one cycle later.
- Backpressure/gaps: same stream with `byte_valid` toggling 1,0,0,1 -> identical writes and data; `byte_ready` low during both WRITE cycles, with no byte lost or duplicated.
- Rejected start: `word_count`=0, then `word_count`=33 -> `err` pulses once each, `busy` stays 0, no `mem_we`. A `start` issued while busy causes no `err` and no restart.
- Reset and abort mid-load: reset after 2 bytes -> outputs zero; a new load of A1 B2 C3 D4 writes 0xA1B2C3D4 at 0x0. Separately, `abort` coincident with the 4th byte of word 1 -> no write to 0x4, no `done`.
- Full depth: `word_count`=32 -> last write at 0x0000007C, `done` asserted, `cpu_hold` high throughout the session.
